// File: rtl/sc_backg_pkg.sv
// Shared definitions for the background timer and the background FSM that drives it:
// state encodings, shift codes and default interval periods.
package sc_backg_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_EXPIRED = 1'b1
  } sc_backg_state_t;

  localparam logic [1:0] SHIFT = 2'b10;
  localparam logic [1:0] HOLD  = 2'b11;

  localparam int unsigned PERIOD_L0_DEFAULT = 8000000;
  localparam int unsigned PERIOD_L1_DEFAULT = 6000000;
  localparam int unsigned PERIOD_L2_DEFAULT = 4000000;
  localparam int unsigned PERIOD_L3_DEFAULT = 2000000;

  function automatic int unsigned period_for_level(input logic [1:0] level,
                                                   input int unsigned p0,
                                                   input int unsigned p1,
                                                   input int unsigned p2,
                                                   input int unsigned p3);
    case (level)
      2'd0:    return p0;
      2'd1:    return p1;
      2'd2:    return p2;
      default: return p3;
    endcase
  endfunction

endpackage

// File: rtl/sc_backg_upcounter.sv
// Interval counter: wraps to zero when it reaches the terminal value `last`,
// with a synchronous clear that overrides enable.
module sc_backg_upcounter #(
  parameter int unsigned DATAWIDTH = 24
) (
  input  logic                 SC_STATEMACHINEBACKG_CLOCK_50,
  input  logic                 SC_STATEMACHINEBACKG_RESET_InHigh,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [DATAWIDTH-1:0] last,
  output logic [DATAWIDTH-1:0] cnt,
  output logic                 terminal
);

  // >= rather than == so a count left above a freshly shortened period still terminates.
  assign terminal = (cnt >= last);

  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
    if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= terminal ? '0 : cnt + DATAWIDTH'(1);
    end
  end

endmodule

// File: rtl/sc_backg_timer.sv
// Background shift timer: counts upcount pulses against a level-selected period and
// holds T0 low until the background FSM acknowledges the shift.
module sc_backg_timer
  import sc_backg_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 24,
  parameter int unsigned PERIOD_L0 = PERIOD_L0_DEFAULT,
  parameter int unsigned PERIOD_L1 = PERIOD_L1_DEFAULT,
  parameter int unsigned PERIOD_L2 = PERIOD_L2_DEFAULT,
  parameter int unsigned PERIOD_L3 = PERIOD_L3_DEFAULT
) (
  input  logic       SC_STATEMACHINEBACKG_CLOCK_50,
  input  logic       SC_STATEMACHINEBACKG_RESET_InHigh,
  input  logic       SC_BACKGTIMER_upcount_InLow,
  input  logic       SC_BACKGTIMER_clear_InLow,
  input  logic [1:0] SC_BACKGTIMER_shiftselection_InBus,
  input  logic [1:0] SC_BACKGTIMER_level_InBus,
  input  logic       SC_BACKGTIMER_pause_InLow,
  output logic       SC_BACKGTIMER_T0_OutLow,
  output logic [7:0] SC_BACKGTIMER_shiftCount_OutBus,
  output logic       SC_BACKGTIMER_state_OutBus
);

  sc_backg_state_t      state_q, state_d;
  logic [DATAWIDTH-1:0] period_q, period_sel, cnt;
  logic [7:0]           shift_count_q;
  logic                 clear_req, ack, ack_taken, count_en, terminal;

  // Handshake: SHIFT on shiftselection acts as valid; the timer is ready only while
  // EXPIRED, so a SHIFT seen in RUN is simply dropped and never queued.
  assign clear_req = ~SC_BACKGTIMER_clear_InLow;
  assign ack       = (SC_BACKGTIMER_shiftselection_InBus == SHIFT);
  assign ack_taken = (state_q == ST_EXPIRED) && ack;
  assign count_en  = (state_q == ST_RUN) && !SC_BACKGTIMER_upcount_InLow
                     && SC_BACKGTIMER_pause_InLow && !clear_req;

  assign period_sel = DATAWIDTH'(period_for_level(SC_BACKGTIMER_level_InBus,
                                                  PERIOD_L0, PERIOD_L1, PERIOD_L2, PERIOD_L3));

  sc_backg_upcounter #(.DATAWIDTH(DATAWIDTH)) u_upcounter (
    .SC_STATEMACHINEBACKG_CLOCK_50     (SC_STATEMACHINEBACKG_CLOCK_50),
    .SC_STATEMACHINEBACKG_RESET_InHigh (SC_STATEMACHINEBACKG_RESET_InHigh),
    .clear                             (clear_req),
    .enable                            (count_en),
    .last                              (period_q - DATAWIDTH'(1)),
    .cnt                               (cnt),
    .terminal                          (terminal)
  );

  always_comb begin
    state_d = state_q;
    if (clear_req) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:     if (count_en && terminal) state_d = ST_EXPIRED;
        ST_EXPIRED: if (ack) state_d = ST_RUN;
        default:    state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
    if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
      state_q       <= ST_RUN;
      period_q      <= DATAWIDTH'(PERIOD_L0);
      shift_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (clear_req || ack_taken) period_q <= period_sel;
      if (clear_req) shift_count_q <= '0;
      else if (ack_taken) shift_count_q <= shift_count_q + 8'd1;
    end
  end

  assign SC_BACKGTIMER_T0_OutLow         = (state_q != ST_EXPIRED);
  assign SC_BACKGTIMER_shiftCount_OutBus = shift_count_q;
  assign SC_BACKGTIMER_state_OutBus      = state_q;

endmodule

// File: tb/tb_sc_backg_timer.sv
// Directed bench for sc_backg_timer with small periods (4/3/2/1): vector table plus
// hand sequences for shift-count wrap and asynchronous reset.
module tb_sc_backg_timer;

  logic       clk;
  logic       rst;
  logic       up_n;
  logic       clr_n;
  logic [1:0] sh;
  logic [1:0] lvl;
  logic       pau_n;
  logic       t0;
  logic [7:0] sc;
  logic       st;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic       up_n;
    logic       clr_n;
    logic [1:0] sh;
    logic [1:0] lvl;
    logic       pau_n;
    logic       t0;
    logic [7:0] sc;
  } vec_t;

  vec_t vec_q[$];

  sc_backg_timer #(
    .DATAWIDTH(24), .PERIOD_L0(4), .PERIOD_L1(3), .PERIOD_L2(2), .PERIOD_L3(1)
  ) dut (
    .SC_STATEMACHINEBACKG_CLOCK_50      (clk),
    .SC_STATEMACHINEBACKG_RESET_InHigh  (rst),
    .SC_BACKGTIMER_upcount_InLow        (up_n),
    .SC_BACKGTIMER_clear_InLow          (clr_n),
    .SC_BACKGTIMER_shiftselection_InBus (sh),
    .SC_BACKGTIMER_level_InBus          (lvl),
    .SC_BACKGTIMER_pause_InLow          (pau_n),
    .SC_BACKGTIMER_T0_OutLow            (t0),
    .SC_BACKGTIMER_shiftCount_OutBus    (sc),
    .SC_BACKGTIMER_state_OutBus         (st)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1 ns after the rising edge
  task automatic step(input logic u, input logic c, input logic [1:0] s,
                      input logic [1:0] l, input logic p);
    @(negedge clk);
    up_n = u; clr_n = c; sh = s; lvl = l; pau_n = p;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic u, input logic c, input logic [1:0] s, input logic [1:0] l,
                     input logic p, input logic e_t0, input logic [7:0] e_sc);
    vec_t v;
    v.up_n = u; v.clr_n = c; v.sh = s; v.lvl = l; v.pau_n = p; v.t0 = e_t0; v.sc = e_sc;
    vec_q.push_back(v);
  endtask

  // upcount pulse / idle cycle shorthands
  task automatic pulse(input logic [1:0] l, input logic e_t0, input logic [7:0] e_sc);
    add(1'b0, 1'b1, 2'b00, l, 1'b1, e_t0, e_sc);
  endtask

  task automatic ack(input logic u, input logic [1:0] l, input logic e_sc);
  endtask

  task automatic build_table();
    // reset interval at level 0: falls on 4th pulse, holds low without ack
    for (int i = 0; i < 3; i++) pulse(2'd0, 1'b1, 8'd0);
    pulse(2'd0, 1'b0, 8'd0);
    for (int i = 0; i < 10; i++) pulse(2'd0, 1'b0, 8'd0);
    // ack releases next edge; SHIFT in RUN ignored; 4 pulses re-expire
    add(1'b1, 1'b1, 2'b10, 2'd0, 1'b1, 1'b1, 8'd1);
    add(1'b1, 1'b1, 2'b10, 2'd0, 1'b1, 1'b1, 8'd1);
    for (int i = 0; i < 3; i++) pulse(2'd0, 1'b1, 8'd1);
    pulse(2'd0, 1'b0, 8'd1);
    // pulse in the ack cycle is not counted
    add(1'b0, 1'b1, 2'b10, 2'd0, 1'b1, 1'b1, 8'd2);
    for (int i = 0; i < 3; i++) pulse(2'd0, 1'b1, 8'd2);
    pulse(2'd0, 1'b0, 8'd2);
    // ack then immediate pulses: exactly 4 to re-expire
    add(1'b1, 1'b1, 2'b10, 2'd0, 1'b1, 1'b1, 8'd3);
    for (int i = 0; i < 3; i++) pulse(2'd0, 1'b1, 8'd3);
    pulse(2'd0, 1'b0, 8'd3);
    // level 0->3 mid-interval: still 4 pulses; afterwards period 1
    add(1'b1, 1'b1, 2'b10, 2'd0, 1'b1, 1'b1, 8'd4);
    pulse(2'd0, 1'b1, 8'd4);
    pulse(2'd3, 1'b1, 8'd4);
    pulse(2'd3, 1'b1, 8'd4);
    pulse(2'd3, 1'b0, 8'd4);
    add(1'b1, 1'b1, 2'b10, 2'd3, 1'b1, 1'b1, 8'd5);
    pulse(2'd3, 1'b0, 8'd5);
    add(1'b1, 1'b1, 2'b10, 2'd3, 1'b1, 1'b1, 8'd6);
    pulse(2'd3, 1'b0, 8'd6);
    add(1'b1, 1'b1, 2'b10, 2'd0, 1'b1, 1'b1, 8'd7);
    // clear together with a pulse at cnt 3
    for (int i = 0; i < 3; i++) pulse(2'd0, 1'b1, 8'd7);
    add(1'b0, 1'b0, 2'b00, 2'd0, 1'b1, 1'b1, 8'd0);
    for (int i = 0; i < 3; i++) pulse(2'd0, 1'b1, 8'd0);
    pulse(2'd0, 1'b0, 8'd0);
    // pause at cnt 2 for 5 pulses
    add(1'b1, 1'b1, 2'b10, 2'd0, 1'b1, 1'b1, 8'd1);
    for (int i = 0; i < 2; i++) pulse(2'd0, 1'b1, 8'd1);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 2'b00, 2'd0, 1'b0, 1'b1, 8'd1);
    pulse(2'd0, 1'b1, 8'd1);
    pulse(2'd0, 1'b0, 8'd1);
    // ack honoured while paused
    add(1'b1, 1'b1, 2'b10, 2'd0, 1'b0, 1'b1, 8'd2);
    for (int i = 0; i < 3; i++) pulse(2'd0, 1'b1, 8'd2);
    pulse(2'd0, 1'b0, 8'd2);
    // clear beats ack and pause in EXPIRED
    add(1'b1, 1'b0, 2'b10, 2'd0, 1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 3; i++) pulse(2'd0, 1'b1, 8'd0);
    pulse(2'd0, 1'b0, 8'd0);
    // clear from EXPIRED reloads period from current level
    add(1'b1, 1'b0, 2'b00, 2'd3, 1'b1, 1'b1, 8'd0);
    pulse(2'd3, 1'b0, 8'd0);
    add(1'b1, 1'b0, 2'b00, 2'd0, 1'b1, 1'b1, 8'd0);
  endtask

  initial begin
    rst = 1'b1; up_n = 1'b1; clr_n = 1'b1; sh = 2'b00; lvl = 2'd0; pau_n = 1'b1;
    #12;
    check("reset_t0", {7'd0, t0}, 8'd1);
    check("reset_sc", sc, 8'd0);
    check("reset_state", {7'd0, st}, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    build_table();
    foreach (vec_q[i]) begin
      step(vec_q[i].up_n, vec_q[i].clr_n, vec_q[i].sh, vec_q[i].lvl, vec_q[i].pau_n);
      check($sformatf("vec%0d_t0", i), {7'd0, t0}, {7'd0, vec_q[i].t0});
      check($sformatf("vec%0d_sc", i), sc, vec_q[i].sc);
    end

    // shiftCount wrap over 256 expire/ack cycles at period 1
    step(1'b1, 1'b0, 2'b00, 2'd3, 1'b1);
    check("wrap_clear_sc", sc, 8'd0);
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(8'((i + 1) % 256));
      step(1'b0, 1'b1, 2'b00, 2'd3, 1'b1);
      check("wrap_expire_t0", {7'd0, t0}, 8'd0);
      step(1'b1, 1'b1, 2'b10, 2'd3, 1'b1);
      check("wrap_ack_t0", {7'd0, t0}, 8'd1);
      check("wrap_sc", sc, exp_q.pop_front());
    end
    check("wrap_final_sc", sc, 8'd0);

    // async reset while EXPIRED, mid-cycle
    step(1'b0, 1'b1, 2'b00, 2'd3, 1'b1);
    step(1'b1, 1'b1, 2'b10, 2'd3, 1'b1);
    step(1'b0, 1'b1, 2'b00, 2'd3, 1'b1);
    check("pre_areset_t0", {7'd0, t0}, 8'd0);
    check("pre_areset_sc", sc, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    check("areset_t0", {7'd0, t0}, 8'd1);
    check("areset_sc", sc, 8'd0);
    check("areset_state", {7'd0, st}, 8'd0);
    @(negedge clk);
    up_n = 1'b1; sh = 2'b00; lvl = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    // period back to level 0: first edge after reset counts
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 2'b00, 2'd0, 1'b1);
      check("post_reset_run", {7'd0, t0}, 8'd1);
    end
    step(1'b0, 1'b1, 2'b00, 2'd0, 1'b1);
    check("post_reset_expire", {7'd0, t0}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // safety net against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout: run did not complete, expected completion before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sc_backg_timer.md
SC_BACKG_TIMER -- requirements
Module: sc_backg_timer

Interface
REQ-001 Parameter DATAWIDTH, default 24: width of interval counter and period values.
REQ-002 Parameter PERIOD_L0, default 8000000: upcount pulses per shift interval at level 0.
REQ-003 Parameters PERIOD_L1/L2/L3, defaults 6000000/4000000/2000000: same for levels 1..3; each SHALL be >= 1 and < 2^DATAWIDTH.
REQ-004 SC_STATEMACHINEBACKG_CLOCK_50  in  1  system clock, 50 MHz.
REQ-005 SC_STATEMACHINEBACKG_RESET_InHigh  in  1  reset, asynchronous, active-high.
REQ-006 SC_BACKGTIMER_upcount_InLow  in  1  count enable from background FSM, active-low, one cycle per pulse.
REQ-007 SC_BACKGTIMER_clear_InLow  in  1  synchronous restart from background FSM, active-low.
REQ-008 SC_BACKGTIMER_shiftselection_InBus  in  2  shift code from background FSM; 2'b10 = shift acknowledge, all other codes = no ack.
REQ-009 SC_BACKGTIMER_level_InBus  in  2  speed level selecting PERIOD_L0..L3.
REQ-010 SC_BACKGTIMER_pause_InLow  in  1  freezes interval counting while low.
REQ-011 SC_BACKGTIMER_T0_OutLow  out  1  interval expired, active-low, level (held until acknowledged).
REQ-012 SC_BACKGTIMER_shiftCount_OutBus  out  8  number of acknowledged shifts since last clear.

Function
REQ-013 Two-state Moore FSM: RUN, EXPIRED; T0_OutLow SHALL be 0 exactly while state = EXPIRED, 1 otherwise, driven from state register only.
REQ-014 Period register SHALL be loaded from table[level_InBus] on clear, on EXPIRED->RUN, and at reset (level 0); level changes at other times SHALL have no effect until the next load.
REQ-015 RUN, upcount_InLow = 0, pause_InLow = 1: if cnt >= period-1 then cnt <= 0 and state <= EXPIRED, else cnt <= cnt+1.
REQ-016 RUN with upcount_InLow = 1 or pause_InLow = 0: cnt and state held.
REQ-017 EXPIRED: upcount pulses ignored, cnt held at 0; on shiftselection_InBus = 2'b10, state <= RUN, period reloaded, shiftCount <= shiftCount+1.
REQ-018 shiftselection_InBus = 2'b10 in RUN SHALL be ignored (no count, no state change).
REQ-019 shiftCount SHALL wrap 255 -> 0 without saturation or flag.
REQ-020 clear_InLow = 0 SHALL, next edge: cnt <= 0, shiftCount <= 0, state <= RUN, period reloaded; clear has priority over upcount, ack and pause.
REQ-021 pause_InLow = 0 SHALL NOT block ack in EXPIRED nor clear.
REQ-022 Latency: T0_OutLow falls on the edge after the terminal upcount pulse; rises on the edge after the ack cycle; ack cycle followed by an upcount cycle SHALL count that pulse as cnt 0->1 (no lost or doubled shift).
REQ-023 Period of 1 SHALL expire on every accepted upcount pulse.

Reset
REQ-024 Reset asserted (any time, incl. mid-interval or EXPIRED): state = RUN, cnt = 0, period = PERIOD_L0, shiftCount = 0, T0_OutLow = 1, immediately and asynchronously.
REQ-025 First counting edge SHALL be the first rising clock edge after reset deasserts.

Structure
REQ-026 Package sc_backg_pkg SHALL hold state encodings, shift codes (SHIFT = 2'b10, HOLD = 2'b11) and default period constants, shared with the background FSM.
REQ-027 One sub-module, sc_backg_upcounter (DATAWIDTH-bit counter with clear, enable, terminal compare), SHALL implement cnt; FSM, period register and shiftCount stay in top.

Verification (sim params PERIOD_L0..L3 = 4/3/2/1)
REQ-028 Reset, level 0, upcount low every cycle -> T0_OutLow falls after 4th pulse edge, stays 0 for 10 cycles without ack.
REQ-029 EXPIRED, ack 2'b10 for one cycle -> T0_OutLow = 1 next edge, shiftCount = 1; following 4 pulses re-expire.
REQ-030 Level changed 0->3 mid-interval -> current interval still 4 pulses; next interval 1 pulse.
REQ-031 clear_InLow and upcount_InLow low in same cycle at cnt = 3 -> cnt = 0, T0_OutLow = 1, shiftCount = 0.
REQ-032 pause_InLow low for 5 pulses at cnt = 2 -> cnt stays 2; ack during pause in EXPIRED still honoured.
REQ-033 256 expire/ack cycles -> shiftCount wraps to 0; async reset in EXPIRED -> T0_OutLow = 1 without clock edge.
